// File: rtl/alu_pwr_pkg.sv
// Shared definitions for the ALU power-sequencing controller: state encoding,
// default timing parameters and the timer sizing helper.
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_ON       = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_ISO_WAIT = 3'd4
  } pwr_state_e;

  localparam int DEF_PWR_UP_CYCLES    = 4;
  localparam int DEF_ISO_SETUP_CYCLES = 2;
  localparam int DEF_IDLE_TIMEOUT     = 64;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int timer_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/alu_pwr_timer.sv
// Loadable down-counter shared by the power-up and isolation-setup waits.
// done flags the final cycle of a wait, so a load of N yields exactly N edges.
module alu_pwr_timer
  import alu_pwr_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/alu_pwr_ctrl.sv
// Power-sequencing controller for the ALU domain: orders isolation and power
// enable, drains in-flight work and gates starts. Optional idle auto power-down
// is built when ALU_PWR_AUTO_OFF_EN is defined.
module alu_pwr_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int PWR_UP_CYCLES    = DEF_PWR_UP_CYCLES,
  parameter int ISO_SETUP_CYCLES = DEF_ISO_SETUP_CYCLES,
  parameter int IDLE_TIMEOUT     = DEF_IDLE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_up_req,
  input  logic       pwr_down_req,
  input  logic       start_in,
  input  logic       alu_busy,
  output logic       start_out,
  output logic       op_stall,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       pwr_ack,
  output logic [2:0] pwr_state
);

  localparam int TMR_MAX = (PWR_UP_CYCLES > ISO_SETUP_CYCLES) ? PWR_UP_CYCLES
                                                              : ISO_SETUP_CYCLES;
  localparam int TMR_W   = timer_width(TMR_MAX);

  if ((PWR_UP_CYCLES < 1) || (ISO_SETUP_CYCLES < 1) || (IDLE_TIMEOUT < 1)) begin : g_param_chk
    $error("alu_pwr_ctrl: cycle-count parameters must be at least 1");
  end

  pwr_state_e state_q;
  pwr_state_e state_d;
  logic       alu_pwr_en_q;
  logic       alu_pwr_en_d;
  logic       iso_en_q;
  logic       iso_en_d;
  logic       pwr_ack_q;
  logic       pwr_ack_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_dec;
  logic             tmr_done;

  logic auto_off;
  logic down_req;

`ifdef ALU_PWR_AUTO_OFF_EN
  localparam int IDLE_W = timer_width(IDLE_TIMEOUT);

  logic [IDLE_W-1:0] idle_cnt_q;
  logic [IDLE_W-1:0] idle_cnt_d;
  logic              idle_cycle;

  // The trigger fires on the cycle that completes the idle run, then restarts.
  always_comb begin
    idle_cycle = (state_q == ST_ON) && !alu_busy && !start_in;
    auto_off   = idle_cycle && (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));
    idle_cnt_d = '0;
    if (idle_cycle && !auto_off) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign auto_off = 1'b0;
`endif

  assign down_req = pwr_down_req | auto_off;

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;

    case (state_q)
      ST_OFF: begin
        // Down beats up (or a start-driven wake) so a requester can pin the domain off.
        if (!pwr_down_req && (pwr_up_req || start_in)) begin
          state_d      = ST_PWR_WAIT;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(PWR_UP_CYCLES);
        end
      end
      ST_PWR_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (down_req) begin
          if (alu_busy) begin
            state_d = ST_DRAIN;
          end else begin
            state_d      = ST_ISO_WAIT;
            tmr_load     = 1'b1;
            tmr_load_val = TMR_W'(ISO_SETUP_CYCLES);
          end
        end
      end
      ST_DRAIN: begin
        if (!alu_busy) begin
          state_d      = ST_ISO_WAIT;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(ISO_SETUP_CYCLES);
        end
      end
      ST_ISO_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    // Outputs decode the next state so they change on the same edge as the state.
    alu_pwr_en_d = (state_d != ST_OFF);
    iso_en_d     = (state_d != ST_ON);
    pwr_ack_d    = ((state_q == ST_PWR_WAIT) && (state_d == ST_ON)) ||
                   ((state_q == ST_ISO_WAIT) && (state_d == ST_OFF));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      alu_pwr_en_q <= 1'b0;
      iso_en_q     <= 1'b1;
      pwr_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_pwr_en_q <= alu_pwr_en_d;
      iso_en_q     <= iso_en_d;
      pwr_ack_q    <= pwr_ack_d;
    end
  end

  alu_pwr_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  assign start_out  = start_in && (state_q == ST_ON) && !down_req;
  assign op_stall   = start_in && !start_out;
  assign alu_pwr_en = alu_pwr_en_q;
  assign iso_en     = iso_en_q;
  assign pwr_ack    = pwr_ack_q;
  assign pwr_state  = state_q;

endmodule
